// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I memory op, word-addressed RAM bus with lane enables,
// load alignment/extension, alignment/range/funct3 fault checks and a bus timeout.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  ck_ref,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_load_storen,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  mem_access_en,
   output logic                  mem_access_read_wrn,
   output logic [3:0]            mem_access_byte_en,
   output logic [ADDR_WIDTH-1:0] mem_access_address_bus,
   output logic [31:0]           mem_access_data_out_bus,
   input  logic [31:0]           mem_access_data_in_bus,
   input  logic                  mem_access_ready,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic [31:0]           wb_data,
   output logic                  fault_valid,
   output logic [1:0]            fault_cause
);

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t          state_reg;
   logic [TW-1:0]   tmo_cnt_reg;
   logic            load_reg;
   logic [2:0]      funct3_reg;
   logic [1:0]      addr_lo_reg;
   logic [4:0]      rd_reg;

   logic            funct3_legal;
   logic            misaligned;
   logic            out_of_range;
   logic [3:0]      byte_en_next;
   logic [31:0]     wdata_next;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [31:0]     load_data;

   // Request screening and lane formatting, evaluated on the incoming op.
   always_comb begin
      if (req_load_storen)
         funct3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                        (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      else
         funct3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i >= ADDR_WIDTH) out_of_range = out_of_range | req_addr[i];
      end
      case (req_funct3[1:0])
         2'b00:   byte_en_next = 4'b0001 << req_addr[1:0];
         2'b01:   byte_en_next = 4'b0011 << req_addr[1:0];
         default: byte_en_next = 4'b1111;
      endcase
      case (req_funct3[1:0])
         2'b00:   wdata_next = {4{req_wdata[7:0]}};
         2'b01:   wdata_next = {2{req_wdata[15:0]}};
         default: wdata_next = req_wdata;
      endcase
   end

   // Load result extraction uses the latched op, since the request bus may already carry the next op.
   always_comb begin
      load_byte = 8'(mem_access_data_in_bus >> {addr_lo_reg, 3'b000});
      load_half = addr_lo_reg[1] ? mem_access_data_in_bus[31:16] : mem_access_data_in_bus[15:0];
      case (funct3_reg)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_data = {24'd0, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b101:  load_data = {16'd0, load_half};
         default: load_data = mem_access_data_in_bus;
      endcase
   end

   always_ff @(posedge ck_ref or negedge rst_n) begin
      if (!rst_n) begin
         state_reg               <= ST_IDLE;
         tmo_cnt_reg             <= '0;
         load_reg                <= 1'b0;
         funct3_reg              <= 3'd0;
         addr_lo_reg             <= 2'd0;
         rd_reg                  <= 5'd0;
         req_ready               <= 1'b0;
         mem_access_en           <= 1'b0;
         mem_access_read_wrn     <= 1'b0;
         mem_access_byte_en      <= 4'd0;
         mem_access_address_bus  <= '0;
         mem_access_data_out_bus <= 32'd0;
         wb_valid                <= 1'b0;
         wb_rd                   <= 5'd0;
         wb_data                 <= 32'd0;
         fault_valid             <= 1'b0;
         fault_cause             <= 2'd0;
      end else begin
         wb_valid    <= 1'b0;
         fault_valid <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  if (!funct3_legal) begin
                     fault_valid <= 1'b1;
                     fault_cause <= 2'b00;
                  end else if (misaligned) begin
                     fault_valid <= 1'b1;
                     fault_cause <= 2'b01;
                  end else if (out_of_range) begin
                     fault_valid <= 1'b1;
                     fault_cause <= 2'b10;
                  end else begin
                     state_reg               <= ST_ACCESS;
                     req_ready               <= 1'b0;
                     tmo_cnt_reg             <= '0;
                     load_reg                <= req_load_storen;
                     funct3_reg              <= req_funct3;
                     addr_lo_reg             <= req_addr[1:0];
                     rd_reg                  <= req_rd;
                     mem_access_en           <= 1'b1;
                     mem_access_read_wrn     <= req_load_storen;
                     mem_access_byte_en      <= byte_en_next;
                     mem_access_address_bus  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_access_data_out_bus <= wdata_next;
                  end
               end
            end
            ST_ACCESS: begin
               // READY on the last allowed cycle still completes the access.
               if (mem_access_ready) begin
                  state_reg     <= ST_IDLE;
                  req_ready     <= 1'b1;
                  mem_access_en <= 1'b0;
                  if (load_reg && (rd_reg != 5'd0)) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= rd_reg;
                     wb_data  <= load_data;
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == TMO_LAST)) begin
                  state_reg     <= ST_IDLE;
                  req_ready     <= 1'b1;
                  mem_access_en <= 1'b0;
                  fault_valid   <= 1'b1;
                  fault_cause   <= 2'b11;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: directed ops push expected bus/WB/fault events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;

   localparam int AW = 16;
   localparam int TO = 15;

   logic          ck_ref = 1'b0;
   logic          rst_n  = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_load_storen = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic [4:0]    req_rd = 5'd0;
   logic          mem_access_en;
   logic          mem_access_read_wrn;
   logic [3:0]    mem_access_byte_en;
   logic [AW-1:0] mem_access_address_bus;
   logic [31:0]   mem_access_data_out_bus;
   logic [31:0]   mem_access_data_in_bus;
   logic          mem_access_ready;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic          fault_valid;
   logic [1:0]    fault_cause;

   load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .ck_ref(ck_ref), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load_storen(req_load_storen),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_access_en(mem_access_en), .mem_access_read_wrn(mem_access_read_wrn),
      .mem_access_byte_en(mem_access_byte_en), .mem_access_address_bus(mem_access_address_bus),
      .mem_access_data_out_bus(mem_access_data_out_bus), .mem_access_data_in_bus(mem_access_data_in_bus),
      .mem_access_ready(mem_access_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .fault_valid(fault_valid), .fault_cause(fault_cause)
   );

   always #5 ck_ref = ~ck_ref;

   int cyc = 0;
   always @(posedge ck_ref) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef enum int {EV_BUS, EV_WB, EV_FAULT} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        rdwrn;
      logic [31:0] dout;
      int          len;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  cause;
      int          at;
   } ev_t;

   ev_t pend_q[$];
   ev_t exp_q[$];

   int          ram_wait    = 0;
   logic [31:0] ram_rdata   = 32'd0;
   logic        stray_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic rdwrn,
                          input logic [31:0] dout, input int len);
      ev_t e;
      e = '{kind: EV_BUS, addr: a, be: be, rdwrn: rdwrn, dout: dout, len: len,
            rd: 5'd0, data: 32'd0, cause: 2'd0, at: 0};
      pend_q.push_back(e);
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d, input int off);
      ev_t e;
      e = '{kind: EV_WB, addr: 32'd0, be: 4'd0, rdwrn: 1'b0, dout: 32'd0, len: 0,
            rd: rd, data: d, cause: 2'd0, at: off};
      pend_q.push_back(e);
   endtask

   task automatic exp_fault(input logic [1:0] c, input int off);
      ev_t e;
      e = '{kind: EV_FAULT, addr: 32'd0, be: 4'd0, rdwrn: 1'b0, dout: 32'd0, len: 0,
            rd: 5'd0, data: 32'd0, cause: c, at: off};
      pend_q.push_back(e);
   endtask

   // Presents one op; pending expectations get absolute cycle stamps relative to the accept edge.
   task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int wt,
                        input logic [31:0] rdat);
      int guard = 0;
      int acc;
      @(negedge ck_ref);
      while (!req_ready && guard < 200) begin
         @(negedge ck_ref);
         guard++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL req_ready_wait: got 0 expected 1 within 200 cycles");
         pend_q.delete();
         return;
      end
      ram_wait  = wt;
      ram_rdata = rdat;
      acc = cyc + 1;
      foreach (pend_q[i]) begin
         ev_t e;
         e = pend_q[i];
         e.at = acc + e.at;
         exp_q.push_back(e);
      end
      pend_q.delete();
      req_load_storen = ld;
      req_funct3      = f3;
      req_addr        = a;
      req_wdata       = wd;
      req_rd          = rd;
      req_valid       = 1'b1;
      $display("op ld=%0b f3=%03b addr=0x%08h wdata=0x%08h rd=%0d wait=%0d", ld, f3, a, wd, rd, wt);
      @(negedge ck_ref);
      req_valid = 1'b0;
   endtask

   task automatic pop_exp(input ev_kind_t k, input string name, output ev_t e, output bit ok);
      ok = 1'b0;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, 32'(e.kind), 32'(k));
         ok = (e.kind == k);
      end
   endtask

   // RAM model: READY on access cycle ram_wait+1 (never when ram_wait<0); stray READY when idle.
   initial begin
      int k;
      k = 0;
      mem_access_ready       = 1'b0;
      mem_access_data_in_bus = 32'd0;
      forever begin
         @(negedge ck_ref);
         mem_access_data_in_bus = ram_rdata;
         if (mem_access_en) begin
            k++;
            mem_access_ready = (ram_wait >= 0) && (k == ram_wait + 1);
         end else begin
            k = 0;
            mem_access_ready = stray_ready;
         end
      end
   end

   // Monitor: bus cycle start/hold/length, write-back and fault pulses.
   initial begin
      ev_t cur;
      ev_t e;
      bit  in_bus;
      bit  ok;
      int  len;
      in_bus = 1'b0;
      len    = 0;
      forever begin
         @(negedge ck_ref);
         if (!rst_n) begin
            in_bus = 1'b0;
            continue;
         end
         if (mem_access_en) begin
            if (!in_bus) begin
               pop_exp(EV_BUS, "bus", e, ok);
               cur    = e;
               in_bus = 1'b1;
               len    = 0;
               if (ok) begin
                  check("bus_addr", 32'(mem_access_address_bus), cur.addr);
                  check("bus_byte_en", 32'(mem_access_byte_en), 32'(cur.be));
                  check("bus_read_wrn", 32'(mem_access_read_wrn), 32'(cur.rdwrn));
                  if (!cur.rdwrn) check("bus_data_out", mem_access_data_out_bus, cur.dout);
               end
            end else if (cur.kind == EV_BUS) begin
               check("hold_addr", 32'(mem_access_address_bus), cur.addr);
               check("hold_byte_en", 32'(mem_access_byte_en), 32'(cur.be));
               if (!cur.rdwrn) check("hold_data_out", mem_access_data_out_bus, cur.dout);
            end
            len++;
         end else if (in_bus) begin
            if (cur.kind == EV_BUS) check("bus_len", 32'(len), 32'(cur.len));
            in_bus = 1'b0;
         end
         if (wb_valid) begin
            pop_exp(EV_WB, "wb", e, ok);
            if (ok) begin
               check("wb_rd", 32'(wb_rd), 32'(e.rd));
               check("wb_data", wb_data, e.data);
               check("wb_cycle", 32'(cyc), 32'(e.at));
               check("wb_req_ready", 32'(req_ready), 32'd1);
            end
            $display("wb rd=%0d data=0x%08h cyc=%0d", wb_rd, wb_data, cyc);
         end
         if (fault_valid) begin
            pop_exp(EV_FAULT, "fault", e, ok);
            if (ok) begin
               check("fault_cause", 32'(fault_cause), 32'(e.cause));
               check("fault_cycle", 32'(cyc), 32'(e.at));
            end
            $display("fault cause=%02b cyc=%0d", fault_cause, cyc);
         end
      end
   end

   initial begin
      repeat (3) @(negedge ck_ref);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_en", 32'(mem_access_en), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_fault_valid", 32'(fault_valid), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      @(negedge ck_ref);
      check("release_req_ready", 32'(req_ready), 32'd1);

      // LW 0xC, zero wait
      exp_bus(32'h000C, 4'b1111, 1'b1, 32'd0, 1);
      exp_wb(5'd5, 32'h1234_5678, 1);
      issue(1'b1, 3'b010, 32'h0000_000C, 32'd0, 5'd5, 0, 32'h1234_5678);
      // LB / LBU lane 3
      exp_bus(32'h0000, 4'b1000, 1'b1, 32'd0, 1);
      exp_wb(5'd6, 32'hFFFF_FF80, 1);
      issue(1'b1, 3'b000, 32'h0000_0003, 32'd0, 5'd6, 0, 32'h80FF_FF00);
      exp_bus(32'h0000, 4'b1000, 1'b1, 32'd0, 1);
      exp_wb(5'd7, 32'h0000_0080, 1);
      issue(1'b1, 3'b100, 32'h0000_0003, 32'd0, 5'd7, 0, 32'h80FF_FF00);
      // SH with 3 wait cycles; ops offered while busy must be dropped
      exp_bus(32'h0000, 4'b1100, 1'b0, 32'hBEEF_BEEF, 4);
      issue(1'b0, 3'b001, 32'h0000_0002, 32'hAAAA_BEEF, 5'd0, 3, 32'd0);
      check("wb_data_hold", wb_data, 32'h0000_0080);
      check("wb_rd_hold", 32'(wb_rd), 32'd7);
      req_load_storen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_rd = 5'd3;
      req_valid = 1'b1;
      repeat (2) @(negedge ck_ref);
      req_valid = 1'b0;
      // faults: misaligned, illegal, out-of-range, priority cases
      exp_fault(2'b01, 0);
      issue(1'b1, 3'b010, 32'h0000_0002, 32'd0, 5'd1, 0, 32'd0);
      exp_fault(2'b00, 0);
      issue(1'b1, 3'b011, 32'h0000_0000, 32'd0, 5'd1, 0, 32'd0);
      exp_fault(2'b10, 0);
      issue(1'b0, 3'b010, 32'h0001_0000, 32'h1111_2222, 5'd0, 0, 32'd0);
      exp_fault(2'b00, 0);
      issue(1'b0, 3'b100, 32'h0001_0003, 32'd0, 5'd0, 0, 32'd0);
      exp_fault(2'b01, 0);
      issue(1'b1, 3'b010, 32'h0001_0002, 32'd0, 5'd2, 0, 32'd0);
      exp_fault(2'b01, 0);
      issue(1'b0, 3'b001, 32'h0000_0001, 32'd0, 5'd0, 0, 32'd0);
      // timeout, then READY on the last allowed cycle
      exp_bus(32'h0010, 4'b1111, 1'b1, 32'd0, TO);
      exp_fault(2'b11, TO);
      issue(1'b1, 3'b010, 32'h0000_0010, 32'd0, 5'd8, -1, 32'd0);
      exp_bus(32'h0014, 4'b1111, 1'b1, 32'd0, TO);
      exp_wb(5'd9, 32'hCAFE_F00D, TO);
      issue(1'b1, 3'b010, 32'h0000_0014, 32'd0, 5'd9, TO - 1, 32'hCAFE_F00D);
      check("fault_cause_hold", 32'(fault_cause), 32'd3);
      // halfword loads upper half, byte/word stores, rd=0 load
      exp_bus(32'h0004, 4'b1100, 1'b1, 32'd0, 1);
      exp_wb(5'd10, 32'hFFFF_8001, 1);
      issue(1'b1, 3'b001, 32'h0000_0006, 32'd0, 5'd10, 0, 32'h8001_1234);
      exp_bus(32'h0004, 4'b1100, 1'b1, 32'd0, 2);
      exp_wb(5'd11, 32'h0000_8001, 2);
      issue(1'b1, 3'b101, 32'h0000_0006, 32'd0, 5'd11, 1, 32'h8001_1234);
      exp_bus(32'h0004, 4'b0010, 1'b0, 32'hA5A5_A5A5, 1);
      issue(1'b0, 3'b000, 32'h0000_0005, 32'h1234_56A5, 5'd0, 0, 32'd0);
      exp_bus(32'h0008, 4'b1111, 1'b0, 32'hDEAD_BEEF, 1);
      issue(1'b0, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 0, 32'd0);
      exp_bus(32'hFFF0, 4'b1111, 1'b1, 32'd0, 1);
      issue(1'b1, 3'b010, 32'h0000_FFF0, 32'd0, 5'd0, 0, 32'h5555_AAAA);
      // READY while idle must do nothing
      @(negedge ck_ref);
      stray_ready = 1'b1;
      repeat (3) @(negedge ck_ref);
      stray_ready = 1'b0;
      // reset in the middle of an access
      exp_bus(32'h0018, 4'b1111, 1'b1, 32'd0, 0);
      issue(1'b1, 3'b010, 32'h0000_0018, 32'd0, 5'd12, -1, 32'd0);
      repeat (3) @(negedge ck_ref);
      #2 rst_n = 1'b0;
      #1;
      check("abort_en", 32'(mem_access_en), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      @(negedge ck_ref);
      rst_n = 1'b1;
      @(negedge ck_ref);
      check("rerelease_req_ready", 32'(req_ready), 32'd1);
      exp_bus(32'h001C, 4'b1111, 1'b1, 32'd0, 1);
      exp_wb(5'd13, 32'h0BAD_F00D, 1);
      issue(1'b1, 3'b010, 32'h0000_001C, 32'd0, 5'd13, 0, 32'h0BAD_F00D);

      repeat (20) @(negedge ck_ref);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
